// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter legality check for sync_fifo_status.
package sync_fifo_pkg;

    // Width of an occupancy counter able to hold 0..depth
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a pointer covering 0..depth-1, never narrower than one bit
    function automatic int ptr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Legal configuration: at least two entries, AE_THRESH < AF_THRESH <= DEPTH
    function automatic bit params_ok(input int depth, input int af, input int ae);
        return (depth >= 2) && (ae >= 0) && (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: counts 0..DEPTH-1 and wraps explicitly to 0, so
// non-power-of-two depths work without an extra wrap bit.
module fifo_wrap_ptr
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW   = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q, ptr_d;

    // Next pointer: advance on inc, wrap after the last slot
    always_comb begin
        ptr_d = ptr_q;
        if (inc) ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end

    // Pointer register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_status.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// registered read port with valid strobe, and read+write accepted on full.
// Optional sticky overflow/underflow flags: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_status
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1,
    localparam int CW        = cnt_width(DEPTH),
    localparam int PW        = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    if (!params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("sync_fifo_status: need DEPTH>=2 and 0<=AE_THRESH<AF_THRESH<=DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         w_ptr, r_ptr;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  rd_valid_q;
    logic                  rd_acc, wr_acc;

    // A write on full only goes in when the same-cycle read frees a slot;
    // reads never bypass from the write port.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_en);

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (.clk(clk), .rst_n(rst_n), .inc(wr_acc), .ptr(w_ptr));
    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (.clk(clk), .rst_n(rst_n), .inc(rd_acc), .ptr(r_ptr));

    // Storage: not reset; same-slot read on full sees the old word via NBA ordering
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) mem[w_ptr] <= data_in;
    end

    // Registered read port and one-cycle valid strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) data_out_q <= mem[r_ptr];
        end
    end

    // Occupancy next-state: simultaneous accept leaves count unchanged
    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign data_out     = data_out_q;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    // Sticky error next-state: a new error beats a same-cycle clear
    always_comb begin
        ovf_d = (wr_en & ~wr_acc) | (ovf_q & ~err_clr);
        udf_d = (rd_en & ~rd_acc) | (udf_q & ~err_clr);
    end

    // Sticky error registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_status.sv
// Bench for sync_fifo_status: a DEPTH=8 and a DEPTH=5 instance share the same
// stimulus; each is checked every cycle against a queue-based model.
module tb_sync_fifo_status;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, wr_en, rd_en, err_clr;
    logic [7:0] data_in;

    logic [7:0] dout8, dout5;
    logic       vld8, vld5, full8, full5, empty8, empty5;
    logic       af8, af5, ae8, ae5, ovf8, ovf5, udf8, udf5;
    logic [3:0] cnt8;
    logic [2:0] cnt5;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model state
    logic [7:0] q8[$];
    logic [7:0] q5[$];
    logic [7:0] m_dout8 = 8'h00, m_dout5 = 8'h00;
    bit         m_vld8, m_vld5, m_ovf8, m_udf8, m_ovf5, m_udf5;

    always #5 clk = ~clk;

    sync_fifo_status #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout8), .rd_valid(vld8), .count(cnt8), .full(full8), .empty(empty8),
        .almost_full(af8), .almost_empty(ae8), .overflow(ovf8), .underflow(udf8),
        .err_clr(err_clr));

    sync_fifo_status #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout5), .rd_valid(vld5), .count(cnt5), .full(full5), .empty(empty5),
        .almost_full(af5), .almost_empty(ae5), .overflow(ovf5), .underflow(udf5),
        .err_clr(err_clr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the models on the edge, compare 1ns later
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit clr, input bit rst);
        int  sz;
        bit  ra, wa;
        wr_en = w; data_in = d; rd_en = r; err_clr = clr; rst_n = ~rst;
        @(posedge clk);
        if (rst) begin
            q8.delete(); q5.delete();
            m_dout8 = 0; m_dout5 = 0; m_vld8 = 0; m_vld5 = 0;
            m_ovf8 = 0; m_udf8 = 0; m_ovf5 = 0; m_udf5 = 0;
        end else begin
            sz = q8.size();
            ra = r && sz > 0;
            wa = w && (sz < 8 || r);
            m_ovf8 = (w && !wa) || (m_ovf8 && !clr);
            m_udf8 = (r && !ra) || (m_udf8 && !clr);
            if (ra) m_dout8 = q8.pop_front();
            m_vld8 = ra;
            if (wa) q8.push_back(d);

            sz = q5.size();
            ra = r && sz > 0;
            wa = w && (sz < 5 || r);
            m_ovf5 = (w && !wa) || (m_ovf5 && !clr);
            m_udf5 = (r && !ra) || (m_udf5 && !clr);
            if (ra) m_dout5 = q5.pop_front();
            m_vld5 = ra;
            if (wa) q5.push_back(d);
        end
        #1;
        chk("d8.count",        32'(cnt8),   32'(q8.size()));
        chk("d8.data_out",     32'(dout8),  32'(m_dout8));
        chk("d8.rd_valid",     32'(vld8),   32'(m_vld8));
        chk("d8.full",         32'(full8),  32'(q8.size() == 8));
        chk("d8.empty",        32'(empty8), 32'(q8.size() == 0));
        chk("d8.almost_full",  32'(af8),    32'(q8.size() >= 6));
        chk("d8.almost_empty", 32'(ae8),    32'(q8.size() <= 1));
        chk("d8.overflow",     32'(ovf8),   32'(ERR_EN & m_ovf8));
        chk("d8.underflow",    32'(udf8),   32'(ERR_EN & m_udf8));
        chk("d5.count",        32'(cnt5),   32'(q5.size()));
        chk("d5.data_out",     32'(dout5),  32'(m_dout5));
        chk("d5.rd_valid",     32'(vld5),   32'(m_vld5));
        chk("d5.full",         32'(full5),  32'(q5.size() == 5));
        chk("d5.empty",        32'(empty5), 32'(q5.size() == 0));
        chk("d5.almost_full",  32'(af5),    32'(q5.size() >= 4));
        chk("d5.almost_empty", 32'(ae5),    32'(q5.size() <= 1));
        chk("d5.overflow",     32'(ovf5),   32'(ERR_EN & m_ovf5));
        chk("d5.underflow",    32'(udf5),   32'(ERR_EN & m_udf5));
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = 8'h00;

        // Reset state
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);

        // Fill DEPTH=8 with 0x01..0x08, then one rejected write
        for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'hEE, 0, 0, 0);
        chk("plan1.full8", 32'(full8), 32'd1);

        // Drain eight, then one rejected read; data_out must hold last word
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        chk("plan2.hold8", 32'(dout8), 32'h08);
        step(0, 8'h00, 0, 1, 0);

        // Full with simultaneous read and write returns the oldest word
        for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'hAA, 1, 0, 0);
        chk("plan3.rw_on_full8", 32'(dout8), 32'h01);
        for (int i = 0; i < 9; i++) step(0, 8'h00, 1, 0, 0);

        // Empty with read and write: read rejected, no bypass
        step(1, 8'h55, 1, 0, 0);
        chk("plan4.no_bypass8", 32'(vld8), 32'd0);
        step(0, 8'h00, 1, 0, 0);
        chk("plan4.next_read8", 32'(dout8), 32'h55);

        // 23 words through DEPTH=5 with occupancy held in 1..4, crossing wraps
        step(0, 8'h00, 0, 1, 1);
        for (int i = 0; i < 23; i++) begin
            if (q5.size() >= 4)      step(1, 8'h30 + 8'(i), 1, 0, 0);
            else if (q5.size() <= 1) step(1, 8'h30 + 8'(i), 0, 0, 0);
            else                     step(1, 8'h30 + 8'(i), ($urandom_range(0, 1) == 1), 0, 0);
        end
        while (q5.size() > 0) step(0, 8'h00, 1, 0, 0);

        // Mid-operation reset with write asserted discards everything
        for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 0, 0, 0);
        step(1, 8'h00, 1, 0, 0);
        step(1, 8'hDD, 0, 0, 1);
        step(0, 8'h00, 1, 0, 0);
        chk("plan6.no_valid_after_reset8", 32'(vld8), 32'd0);

        // Randomised traffic in phases that push towards full then empty
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 40; i++) begin
                int  pw;
                bit  w, r, clr, rst;
                pw  = (b % 2 == 0) ? 75 : 25;
                w   = ($urandom_range(0, 99) < pw);
                r   = ($urandom_range(0, 99) < (100 - pw));
                clr = ($urandom_range(0, 99) < 8);
                rst = ($urandom_range(0, 199) == 0);
                step(w, 8'($urandom), r, clr, rst);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_status.md
Name: sync_fifo_status

Overview:
Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty thresholds, a registered read port with a valid strobe, and simultaneous read/write on full.
Supports any DEPTH >= 2, including non-power-of-two.
Drop-in buffer between streaming producers and consumers in the same clock domain.
Also serves as the DUT for the next round of cocotb regression.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 8, number of entries (>= 2; need not be a power of two)
AF_THRESH, 6, almost_full asserts when count >= AF_THRESH (AE_THRESH < AF_THRESH <= DEPTH)
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0 <= AE_THRESH)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
wr_en  in  1  write request
data_in  in  DATA_WIDTH  write data
rd_en  in  1  read request
data_out  out  DATA_WIDTH  registered read data
rd_valid  out  1  data_out updated this cycle (1-cycle pulse)
count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
overflow  out  1  sticky: write was rejected
underflow  out  1  sticky: read was rejected
err_clr  in  1  clears overflow/underflow

Behaviour:
- Reset (rst_n=0 at posedge) clears the following:
  - w_ptr, r_ptr, count, data_out and rd_valid go to 0.
  - overflow and underflow go to 0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 ? n/a : 0).
  - Storage array is not reset.
  - Reset overrides wr_en/rd_en. Mid-operation reset discards all contents.
- Pointers run 0..DEPTH-1 and wrap explicitly to 0; there is no MSB wrap bit. Full/empty are derived only from count.
- Accept rules:
  - rd_acc = rd_en & !empty
  - wr_acc = wr_en & (!full | rd_en)
  - A write on full is accepted only when a read is accepted in the same cycle.
  - A read on empty is rejected even with a concurrent write; there is no bypass.
- Write: on wr_acc, mem[w_ptr] <= data_in and w_ptr advances with wrap.
- Read:
  - On rd_acc: data_out <= mem[r_ptr], r_ptr advances with wrap, and rd_valid=1 in the next cycle.
  - Otherwise data_out holds its value and rd_valid=0.
  - Latency from the rd_en edge to data_out is 1 clock.
- Full + simultaneous read/write: the read returns the old oldest word (read-before-write on the same slot). count stays at DEPTH.
- count update:
  - wr_acc only: +1
  - rd_acc only: -1
  - both or neither: unchanged
  - count never exceeds DEPTH and never goes below 0.
- Status flags are combinational from the count register, so they change in the cycle after the accepting edge.
- Data ordering is strict FIFO across any number of wraps.

Optional Feature:
- Macro SYNC_FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on wr_en & !wr_acc; underflow sets on rd_en & !rd_acc.
  - Both are sticky until err_clr=1 or reset.
  - If err_clr and a new error occur in the same cycle, the set wins.
- Undefined: overflow and underflow are tied to 0, err_clr is ignored, and no flag registers are synthesised.

Decomposition:
- Package sync_fifo_pkg holds:
  - function cnt_width(depth) = $clog2(depth+1)
  - function ptr_width(depth) = max(1, $clog2(depth))
  - elaboration-time parameter legality checks (DEPTH >= 2, AE_THRESH < AF_THRESH <= DEPTH)
- One sub-module, fifo_wrap_ptr:
  - Parameter DEPTH; inputs clk, rst_n, inc; output ptr.
  - Wraps to 0 after DEPTH-1.
  - Instantiated twice, for the write and read pointers.

Test Plan:
1. DEPTH=8, reset, write 0x01..0x08 -> full=1 and count=8 after the 8th edge; almost_full=1 from count=6; a 9th write sets overflow; contents unchanged.
2. From full, read 8 times -> data_out 0x01..0x08 each one cycle after rd_en with rd_valid pulses; empty=1, almost_empty=1 at count<=1; a 9th read sets underflow; data_out holds 0x08.
3. Full with rd_en=wr_en=1 and data_in=0xAA -> data_out=0x01, count stays 8; a subsequent drain yields 0x02..0x08 then 0xAA.
4. Empty with rd_en=wr_en=1 and data_in=0x55 -> read rejected, rd_valid=0, count=1; the next read returns 0x55.
5. DEPTH=5, 23 writes interleaved with reads, keeping count between 1 and 4 -> output sequence equals input sequence across pointer wraps.
6. Write 3 words then assert rst_n=0 with wr_en=1 -> count=0, empty=1, sticky flags cleared; after release, the first read on empty returns no rd_valid.
